uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Shares the single UART transmitter between two frame sources, e.g. the register-file read path and the ALU result path.
- Arbitrates round-robin between them and splits each request into one or two bytes.
- Sequences every byte through the transmitter's Data_Valid/busy handshake.
- Sits between the system controller outputs and the UART TX top.

Parameters:
DATA_WIDTH, 8, width of one UART byte.
BUSY_TO, 8, maximum cycles to wait for TX_BUSY to rise after a TX_D_VLD pulse before declaring a timeout (must be ≥3).

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
REQ0  in  1  requester 0 frame request; held until REQ0_ACK
REQ0_DATA  in  2*DATA_WIDTH  requester 0 payload; low byte is sent first
REQ0_LEN  in  1  0 = 1 byte (low byte only), 1 = 2 bytes
REQ0_ACK  out  1  one-cycle pulse when requester 0's frame completes or aborts
REQ1, REQ1_DATA, REQ1_LEN, REQ1_ACK  same as above for requester 1
TX_P_DATA  out  DATA_WIDTH  byte presented to the UART TX
TX_D_VLD  out  1  one-cycle data-valid pulse to the UART TX
TX_BUSY  in  1  registered busy from the UART TX
SCHED_BUSY  out  1  high in every state except IDLE
TIMEOUT_ERR  out  1  sticky flag; set on a busy timeout, cleared only by RST

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = requester 0, byte index 0, timeout counter 0. A reset mid-frame aborts the frame with no ACK.
- States (registered, binary encoded): IDLE, LOAD, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - Grants only when TX_BUSY=0 and at least one REQ is high.
  - Winner: the only requester asking; if both ask, the requester named by the RR pointer.
  - On grant, latch DATA/LEN/id, set byte index 0, and set the RR pointer to the other requester. Next state LOAD.
- LOAD (exactly 1 cycle):
  - TX_D_VLD=1; TX_P_DATA = latched byte[index].
  - Clear the timeout counter. Next state WAIT_HI.
- WAIT_HI:
  - If TX_BUSY=1, next state WAIT_LO.
  - Otherwise increment the counter. When the counter reaches BUSY_TO-1 with TX_BUSY still 0: set TIMEOUT_ERR, abort the remaining bytes, next state DONE.
  - The transmitter's busy rises 2 cycles after the D_VLD pulse; BUSY_TO covers this.
- WAIT_LO: when TX_BUSY=0:
  - If index < LEN, increment index and go to LOAD.
  - Otherwise go to DONE.
- DONE (exactly 1 cycle): pulse ACK of the latched id, then return to IDLE.
- TX_P_DATA is held at the current byte from LOAD until the next LOAD; it is not cleared in IDLE.
- Latency: REQ sampled high in IDLE at cycle N → TX_D_VLD at N+1.
  - ACK comes 1 cycle after the final TX_BUSY fall is sampled.
  - With an idle requester and TX_BUSY low, the next grant is possible in the cycle after DONE.
- Request rules:
  - REQx, DATA and LEN are sampled only at grant; later changes are ignored.
  - Dropping REQ before grant withdraws it.
  - REQ still high in the cycle after its ACK counts as a new frame.
- Simultaneous events:
  - Both requests in IDLE: the pointer decides, so the two requesters strictly alternate under saturation.
  - A request arriving during DONE waits for IDLE.
- TX_BUSY high on entry to IDLE (foreign use of the transmitter): stall in IDLE with no grant.
- TIMEOUT_ERR does not block further operation.

Decomposition:
- Shared package uart_pkg:
  - state encodings for IDLE/LOAD/WAIT_HI/WAIT_LO/DONE;
  - DATA_WIDTH default;
  - LEN encodings (LEN_1B=0, LEN_2B=1).
- One sub-module rr_arb2:
  - 2-input round-robin arbiter holding the pointer register;
  - inputs req[1:0] and an advance strobe; output one-hot grant.
- FSM, byte mux and timeout counter stay in uart_tx_sched.

Test Plan:
- REQ0=1, LEN=0, DATA=16'h12A5; TX model raises busy 2 cycles after D_VLD for 11 cycles → one D_VLD with TX_P_DATA=8'hA5, REQ0_ACK pulse 1 cycle after busy falls, TIMEOUT_ERR=0.
- REQ1=1, LEN=1, DATA=16'hBEEF → two D_VLD pulses, 8'hEF then 8'hBE; the second pulse comes only after busy falls; exactly one REQ1_ACK.
- REQ0 and REQ1 both held high continuously, LEN=0, from reset → grant order 0,1,0,1; each ACK pulse is 1 cycle wide.
- TX model never raises busy, BUSY_TO=8 → after D_VLD, TIMEOUT_ERR=1 at the 8th WAIT_HI cycle, ACK pulse, return to IDLE; the next request is still served and TIMEOUT_ERR stays 1.
- Assert RST during WAIT_LO of a 2-byte frame → next cycle all outputs 0, no ACK, no second byte; after release REQ0 wins the first tie.
- Hold TX_BUSY=1 before raising REQ0 → no D_VLD until TX_BUSY=0; then D_VLD in the cycle after the grant.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit scheduler:
//   - default byte width
//   - scheduler FSM state encodings (binary, 3 bits)
//   - frame length encodings carried on REQx_LEN
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Scheduler FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Frame length encodings
  localparam logic LEN_1B = 1'b0;
  localparam logic LEN_2B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. The pointer names the requester that wins a
// tie; after a taken grant it moves to the other requester so that two
// saturated requesters strictly alternate.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (pointer -> requester 0)
//   req  : request vector, bit i = requester i
//   adv  : strobe, the current grant is being taken this cycle
//   gnt  : one-hot grant (combinational), 2'b00 when nobody asks
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer update
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // After serving requester 0 the pointer names 1, and vice versa
    if (adv && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmitter between two frame sources. Each granted frame
// is one or two bytes (low byte first); every byte is pushed through the
// transmitter's TX_D_VLD / TX_BUSY handshake. A missing busy response is
// caught by a timeout that raises a sticky error and aborts the frame.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   REQx, REQx_DATA,
//   REQx_LEN, REQx_ACK  : requester x frame interface (x = 0, 1)
//   TX_P_DATA, TX_D_VLD : byte and one-cycle valid towards the UART TX
//   TX_BUSY             : registered busy from the UART TX
//   SCHED_BUSY          : high whenever the FSM is not IDLE
//   TIMEOUT_ERR         : sticky busy-timeout flag, cleared only by RST
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUSY_TO    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0,
  input  logic [2*DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                    REQ0_LEN,
  output logic                    REQ0_ACK,
  input  logic                    REQ1,
  input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
  input  logic                    REQ1_LEN,
  output logic                    REQ1_ACK,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  output logic                    SCHED_BUSY,
  output logic                    TIMEOUT_ERR
);

  localparam int CW = $clog2(BUSY_TO + 1);

  logic [2:0]              state_q, state_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    len_q, len_d;
  logic                    id_q, id_d;
  logic                    idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
  logic                    tx_d_vld_q, tx_d_vld_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;
  logic                    sched_busy_q, sched_busy_d;
  logic                    timeout_err_q, timeout_err_d;

  logic [1:0]              gnt;
  logic                    adv;
  logic [2*DATA_WIDTH-1:0] gnt_data;

  rr_arb2 u_arb (
    .clk (CLK),
    .rst (RST),
    .req ({REQ1, REQ0}),
    .adv (adv),
    .gnt (gnt)
  );

  assign gnt_data = gnt[1] ? REQ1_DATA : REQ0_DATA;

  // Next-state, byte mux, timeout counter and output pulse generation.
  // TX_D_VLD and the ACKs are computed on the transition into LOAD / DONE so
  // that their registered copies are high exactly during those states.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    len_d         = len_q;
    id_d          = id_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tx_p_data_d   = tx_p_data_q;
    tx_d_vld_d    = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    adv           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A busy transmitter here means someone else is using it: stall
        if (!TX_BUSY && (gnt != 2'b00)) begin
          adv         = 1'b1;
          id_d        = gnt[1];
          data_d      = gnt_data;
          len_d       = gnt[1] ? REQ1_LEN : REQ0_LEN;
          idx_d       = 1'b0;
          tx_p_data_d = gnt_data[DATA_WIDTH-1:0];
          tx_d_vld_d  = 1'b1;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        cnt_d   = {CW{1'b0}};
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (TX_BUSY) begin
          state_d = ST_WAIT_LO;
        end else if (cnt_q == CW'(BUSY_TO - 1)) begin
          // Transmitter never answered: flag it and drop any remaining byte
          timeout_err_d = 1'b1;
          ack0_d        = ~id_q;
          ack1_d        = id_q;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WAIT_LO: begin
        if (!TX_BUSY) begin
          if ((idx_q == 1'b0) && (len_q == LEN_2B)) begin
            idx_d       = 1'b1;
            tx_p_data_d = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_d_vld_d  = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            ack0_d  = ~id_q;
            ack1_d  = id_q;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WAIT_LO;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sched_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      data_q        <= {(2*DATA_WIDTH){1'b0}};
      len_q         <= 1'b0;
      id_q          <= 1'b0;
      idx_q         <= 1'b0;
      cnt_q         <= {CW{1'b0}};
      tx_p_data_q   <= {DATA_WIDTH{1'b0}};
      tx_d_vld_q    <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      sched_busy_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      len_q         <= len_d;
      id_q          <= id_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      sched_busy_q  <= sched_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign TX_P_DATA   = tx_p_data_q;
  assign TX_D_VLD    = tx_d_vld_q;
  assign REQ0_ACK    = ack0_q;
  assign REQ1_ACK    = ack1_q;
  assign SCHED_BUSY  = sched_busy_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched. A small transmitter model raises
// busy two cycles after each TX_D_VLD and holds it for HOLD cycles. A monitor
// logs every TX_D_VLD byte and every ACK with its cycle number; checks compare
// those logs against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int DW   = 8;
  localparam int HOLD = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, len0, len1;
  logic [15:0]   d0, d1;
  logic          ack0, ack1;
  logic [7:0]    txd;
  logic          vld;
  logic          tx_busy;
  logic          sbusy, terr;

  logic          mb = 1'b0;
  logic          pend = 1'b0;
  int            rem = 0;
  bit            model_en = 1'b1;
  bit            force_busy = 1'b0;

  int            total = 0;
  int            bad = 0;

  int            cyc = 0;
  int            vld_cyc[$];
  logic [7:0]    vld_byte[$];
  int            ack_cyc[$];
  int            ack_id[$];
  int            wide_err = 0;
  logic          p0 = 1'b0;
  logic          p1 = 1'b0;

  always #5 clk = ~clk;

  assign tx_busy = mb | force_busy;

  uart_tx_sched #(.DATA_WIDTH(DW), .BUSY_TO(8)) dut (
    .CLK         (clk),
    .RST         (rst),
    .REQ0        (req0),
    .REQ0_DATA   (d0),
    .REQ0_LEN    (len0),
    .REQ0_ACK    (ack0),
    .REQ1        (req1),
    .REQ1_DATA   (d1),
    .REQ1_LEN    (len1),
    .REQ1_ACK    (ack1),
    .TX_P_DATA   (txd),
    .TX_D_VLD    (vld),
    .TX_BUSY     (tx_busy),
    .SCHED_BUSY  (sbusy),
    .TIMEOUT_ERR (terr)
  );

  // Transmitter model: busy high from 2 cycles after D_VLD for HOLD cycles
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    pend <= vld && model_en;
    if (pend) begin
      mb  <= 1'b1;
      rem <= HOLD - 1;
    end else if (mb) begin
      if (rem == 0) mb <= 1'b0;
      else rem <= rem - 1;
    end
  end

  // Monitor: log bytes and ACKs, count ACKs longer than one cycle
  always @(negedge clk) begin
    if (vld) begin
      vld_cyc.push_back(cyc);
      vld_byte.push_back(txd);
    end
    if (ack0) begin
      ack_cyc.push_back(cyc);
      ack_id.push_back(0);
    end
    if (ack1) begin
      ack_cyc.push_back(cyc);
      ack_id.push_back(1);
    end
    if ((ack0 && p0) || (ack1 && p1)) wide_err <= wide_err + 1;
    p0 <= ack0;
    p1 <= ack1;
  end

  typedef struct {
    logic        id;
    logic        len;
    logic [15:0] data;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (ack_id.size() < target && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(ack_id.size() >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sbusy || mb || pend) && k < 200) begin
      step();
      k++;
    end
    chk("wait_idle", 32'(sbusy || mb || pend), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_txd"}, 32'(txd), 32'd0);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_ack"}, 32'({ack1, ack0}), 32'd0);
    chk({tag, "_sbusy"}, 32'(sbusy), 32'd0);
    chk({tag, "_terr"}, 32'(terr), 32'd0);
  endtask

  initial begin
    int vb, ab, n, w0, p;

    vecs[0] = '{1'b0, 1'b0, 16'h12A5, 1, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 16'hBEEF, 2, 8'hEF, 8'hBE};
    vecs[2] = '{1'b0, 1'b1, 16'h00FF, 2, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 16'h5A3C, 1, 8'h3C, 8'h00};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = 1'b0; len1 = 1'b0;
    d0 = 16'h0000; d1 = 16'h0000;
    repeat (3) step();
    chk_outputs_zero("rst_hold");
    rst = 1'b0;
    step();
    chk_outputs_zero("rst_rel");

    // Single-requester frames from the table
    for (int i = 0; i < 4; i++) begin
      vb = vld_byte.size();
      ab = ack_id.size();
      if (vecs[i].id) begin
        req1 = 1'b1; d1 = vecs[i].data; len1 = vecs[i].len;
      end else begin
        req0 = 1'b1; d0 = vecs[i].data; len0 = vecs[i].len;
      end
      n = cyc;
      wait_acks(ab + 1, 300, $sformatf("v%0d_ack_seen", i));
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle();
      chk($sformatf("v%0d_nbytes", i), 32'(vld_byte.size() - vb), 32'(vecs[i].nbytes));
      chk($sformatf("v%0d_nacks", i), 32'(ack_id.size() - ab), 32'd1);
      if (vld_byte.size() > vb) begin
        chk($sformatf("v%0d_b0", i), 32'(vld_byte[vb]), 32'(vecs[i].b0));
        chk($sformatf("v%0d_lat", i), 32'(vld_cyc[vb]), 32'(n + 1));
      end
      if (vecs[i].nbytes == 2 && vld_byte.size() > vb + 1) begin
        chk($sformatf("v%0d_b1", i), 32'(vld_byte[vb + 1]), 32'(vecs[i].b1));
        chk($sformatf("v%0d_gap", i), 32'(vld_cyc[vb + 1] - vld_cyc[vb]), 32'd14);
      end
      if (ack_id.size() > ab && vld_cyc.size() > 0) begin
        chk($sformatf("v%0d_ack_id", i), 32'(ack_id[ab]), 32'(vecs[i].id));
        chk($sformatf("v%0d_ack_lat", i), 32'(ack_cyc[ab] - vld_cyc[vld_cyc.size() - 1]), 32'd14);
      end
      chk($sformatf("v%0d_terr", i), 32'(terr), 32'd0);
    end

    // Saturation from reset: strict alternation, 1-cycle ACKs
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; len0 = 1'b0; len1 = 1'b0;
    d0 = 16'h0011; d1 = 16'h0022;
    repeat (2) step();
    vb = vld_byte.size();
    ab = ack_id.size();
    w0 = wide_err;
    rst = 1'b0;
    wait_acks(ab + 4, 400, "sat_ack_seen");
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      if (ack_id.size() > ab + k) chk($sformatf("sat_ack%0d", k), 32'(ack_id[ab + k]), 32'(k % 2));
      if (vld_byte.size() > vb + k)
        chk($sformatf("sat_byte%0d", k), 32'(vld_byte[vb + k]), (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    chk("sat_ack_width", 32'(wide_err - w0), 32'd0);

    // Busy timeout: model silent, error set, ACK still given
    model_en = 1'b0;
    vb = vld_byte.size();
    ab = ack_id.size();
    req0 = 1'b1; d0 = 16'h0077; len0 = 1'b0;
    n = cyc;
    wait_acks(ab + 1, 100, "to_ack_seen");
    chk("to_terr_at_ack", 32'(terr), 32'd1);
    req0 = 1'b0;
    if (ack_cyc.size() > ab) chk("to_ack_lat", 32'(ack_cyc[ab] - n), 32'd10);
    chk("to_nbytes", 32'(vld_byte.size() - vb), 32'd1);
    model_en = 1'b1;
    wait_idle();
    vb = vld_byte.size();
    ab = ack_id.size();
    req1 = 1'b1; d1 = 16'h0042; len1 = 1'b0;
    wait_acks(ab + 1, 100, "to_next_ack_seen");
    req1 = 1'b0;
    wait_idle();
    if (vld_byte.size() > vb) chk("to_next_byte", 32'(vld_byte[vb]), 32'h42);
    if (ack_id.size() > ab) chk("to_next_ack_id", 32'(ack_id[ab]), 32'd1);
    chk("to_terr_sticky", 32'(terr), 32'd1);

    // Reset during WAIT_LO of a 2-byte frame
    vb = vld_byte.size();
    ab = ack_id.size();
    req0 = 1'b1; d0 = 16'h8877; len0 = 1'b1;
    p = 0;
    while (!mb && p < 50) begin
      step();
      p++;
    end
    step();
    rst = 1'b1;
    req0 = 1'b0;
    step();
    chk_outputs_zero("mid_rst");
    chk("mid_rst_nbytes", 32'(vld_byte.size() - vb), 32'd1);
    vb = vld_byte.size();
    req0 = 1'b1; req1 = 1'b1; d0 = 16'h0011; d1 = 16'h0022; len0 = 1'b0; len1 = 1'b0;
    rst = 1'b0;
    wait_acks(ab + 1, 200, "mid_rst_ack_seen");
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();
    chk("mid_rst_nacks", 32'(ack_id.size() - ab), 32'd1);
    if (ack_id.size() > ab) chk("mid_rst_tie_id", 32'(ack_id[ab]), 32'd0);
    if (vld_byte.size() > vb) chk("mid_rst_tie_byte", 32'(vld_byte[vb]), 32'h11);
    chk("mid_rst_nbytes_after", 32'(vld_byte.size() - vb), 32'd1);

    // Foreign busy stalls the grant
    vb = vld_byte.size();
    ab = ack_id.size();
    force_busy = 1'b1;
    req0 = 1'b1; d0 = 16'h0033; len0 = 1'b0;
    repeat (5) step();
    chk("stall_no_vld", 32'(vld_byte.size() - vb), 32'd0);
    chk("stall_sbusy", 32'(sbusy), 32'd0);
    force_busy = 1'b0;
    p = cyc;
    wait_acks(ab + 1, 100, "stall_ack_seen");
    req0 = 1'b0;
    wait_idle();
    if (vld_byte.size() > vb) begin
      chk("stall_lat", 32'(vld_cyc[vb]), 32'(p + 1));
      chk("stall_byte", 32'(vld_byte[vb]), 32'h33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
